step_display_ctrl: RTL

//  Board-side front end of the single-cycle CPU: debounces the step push-button and emits exactly one

---
 rtl/step_display_ctrl_pkg.sv | 25 ++
 rtl/step_display_ctrl_hex_to_seg7.sv | 15 +
 rtl/step_display_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/step_display_ctrl_pkg.sv
// Shared definitions for the step/display front end: pulse FSM states and
// the active-low 7-segment hex glyph table.
`default_nettype none

package step_display_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HOLD = 2'd2
  } pulse_state_t;

  // Bit order {dp,g,f,e,d,c,b,a}; element n is the glyph for nibble n.
  localparam logic [15:0][7:0] SEG7_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg7_of(input logic [3:0] nibble);
    return SEG7_HEX[nibble];
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_display_ctrl_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern (dp always off).
`default_nettype none

module hex_to_seg7
  import step_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = seg7_of(nibble);

endmodule

`default_nettype wire

// File: rtl/step_display_ctrl.sv
// Step button debouncer producing one CPU clock pulse per press, plus a
// 4-digit multiplexed hex display of one selected CPU debug word.
`default_nettype none

module step_display_ctrl
  import step_display_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int SCAN_CYC     = 100_000,
  parameter int PULSE_CYC    = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        btn_step,
  input  logic [1:0]  sel,
  input  logic [15:0] sign1,
  input  logic [15:0] sign2,
  input  logic [15:0] sign3,
  input  logic [15:0] sign4,
  output logic        cpu_clk,
  output logic [15:0] step_cnt,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int SC_W = (SCAN_CYC > 1)     ? $clog2(SCAN_CYC)     : 1;
  localparam int PC_W = (PULSE_CYC > 1)    ? $clog2(PULSE_CYC)    : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYC - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_CYC - 1);

  logic            sync_q1;
  logic            sync_q2;
  logic            stable;
  logic            stable_d;
  logic [DB_W-1:0] db_cnt;
  logic            rise;

  pulse_state_t    state;
  pulse_state_t    state_nxt;
  logic [PC_W-1:0] pcnt;
  logic [PC_W-1:0] pcnt_nxt;
  logic [15:0]     step_cnt_nxt;
  logic            cpu_clk_nxt;

  logic [SC_W-1:0] scan_cnt;
  logic [1:0]      digit;
  logic [15:0]     word;
  logic [3:0]      nibble;
  logic [7:0]      seg_pat;

  // Two-flop synchronizer: the only consumer of the raw button.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_step;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has held for DEBOUNCE_CYC cycles.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      stable <= 1'b0;
      db_cnt <= '0;
    end else if (sync_q2 == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      stable <= sync_q2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
    end
  end

  assign rise = stable & ~stable_d;

  always_comb begin
    state_nxt    = state;
    pcnt_nxt     = pcnt;
    step_cnt_nxt = step_cnt;
    unique case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt    = ST_LOW;
          pcnt_nxt     = '0;
          step_cnt_nxt = step_cnt + 16'd1;
        end
      end
      ST_LOW: begin
        if (pcnt == PC_LAST) begin
          state_nxt = ST_HOLD;
          pcnt_nxt  = '0;
        end else begin
          pcnt_nxt = pcnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stable) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        pcnt_nxt  = '0;
      end
    endcase
    // Registered from the next state so the CPU clock comes straight off a flop.
    cpu_clk_nxt = (state_nxt != ST_LOW);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      pcnt     <= '0;
      step_cnt <= 16'd0;
      cpu_clk  <= 1'b1;
    end else begin
      state    <= state_nxt;
      pcnt     <= pcnt_nxt;
      step_cnt <= step_cnt_nxt;
      cpu_clk  <= cpu_clk_nxt;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (scan_cnt == SC_LAST) begin
      scan_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    word = sign1;
    unique case (sel)
      2'd0: word = sign1;
      2'd1: word = sign2;
      2'd2: word = sign3;
      2'd3: word = sign4;
      default: word = sign1;
    endcase
  end

  assign nibble = word[{digit, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (seg_pat)
  );

  // Display registers track sel/sign every cycle, not just at digit boundaries.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      an  <= ~(4'b0001 << digit);
      seg <= seg_pat;
    end
  end

endmodule

`default_nettype wire
